// File: rtl/seg_scan_driver_if.sv
// Bus bundle between the display core and the seven-segment scan driver.
// The core drives the segment patterns and controls; the driver returns the pad drives.
interface seg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 6
);
    logic [7*NUM_DIGITS-1:0] segBus_I;
    logic                    latchEn_I;
    logic [NUM_DIGITS-1:0]   digitEnable_I;
    logic [6:0]              segment_O;
    logic [NUM_DIGITS-1:0]   anode_O;
    logic                    frameDone_O;

    modport master (
        output segBus_I, latchEn_I, digitEnable_I,
        input  segment_O, anode_O, frameDone_O
    );

    modport slave (
        input  segBus_I, latchEn_I, digitEnable_I,
        output segment_O, anode_O, frameDone_O
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner: one digit per slot, blank guard at slot start,
// segment bus captured only at frame start so the display never tears mid-scan.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic             clk_I,
    input  logic             reset_I,
    seg_scan_driver_if.slave bus
);
    localparam int unsigned SEG_W = 7;
    localparam int unsigned BUS_W = SEG_W * NUM_DIGITS;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [SEG_W-1:0]      SEG_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {BLANK, DRIVE} phase_t;

    phase_t                r_phase;
    phase_t                w_phase_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [BUS_W-1:0]      r_shadow;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [SEG_W-1:0]      r_segment;
    logic                  r_frame_done;

    logic                  w_slot_end;
    logic                  w_idx_last;
    logic                  w_frame_start;
    logic                  w_lit;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [NUM_DIGITS-1:0] w_anode_nxt;
    logic [SEG_W-1:0]      w_segment_nxt;

    // Phase state register
    always_ff @(posedge clk_I or posedge reset_I) begin
        if (reset_I) r_phase <= BLANK;
        else         r_phase <= w_phase_nxt;
    end

    // Next phase, slot counters and decoded output drive
    always_comb begin
        w_phase_nxt   = r_phase;
        w_slot_end    = (r_cnt == CNT_W'(REFRESH_DIV - 1));
        w_idx_last    = (r_idx == IDX_W'(NUM_DIGITS - 1));
        w_frame_start = (r_idx == '0) && (r_cnt == '0);
        w_cnt_nxt     = w_slot_end ? '0 : r_cnt + CNT_W'(1);
        w_idx_nxt     = r_idx;
        w_lit         = 1'b0;
        w_anode_nxt   = ANODE_OFF;
        w_segment_nxt = SEG_OFF;

        if (w_slot_end) w_idx_nxt = w_idx_last ? '0 : r_idx + IDX_W'(1);

        case (r_phase)
            BLANK:   if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) w_phase_nxt = DRIVE;
            DRIVE:   if (w_slot_end) w_phase_nxt = BLANK;
            default: w_phase_nxt = BLANK;
        endcase

        w_lit = (r_phase == DRIVE) && bus.digitEnable_I[r_idx];
        if (w_lit) begin
            w_anode_nxt   = NUM_DIGITS'(1) << r_idx;
            w_segment_nxt = r_shadow[SEG_W*32'(r_idx) +: SEG_W];
            // Shadow holds active-high patterns; polarity is applied only at the pads.
            if (ACTIVE_LOW != 0) begin
                w_anode_nxt   = ~w_anode_nxt;
                w_segment_nxt = ~w_segment_nxt;
            end
        end
    end

    // Counters, frame capture and registered pad drives
    always_ff @(posedge clk_I or posedge reset_I) begin
        if (reset_I) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_anode      <= ANODE_OFF;
            r_segment    <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_anode      <= w_anode_nxt;
            r_segment    <= w_segment_nxt;
            r_frame_done <= w_slot_end && w_idx_last;
            if (w_frame_start && bus.latchEn_I) r_shadow <= bus.segBus_I;
        end
    end

    assign bus.anode_O     = r_anode;
    assign bus.segment_O   = r_segment;
    assign bus.frameDone_O = r_frame_done;
endmodule
